// File: rtl/dot_pkg.sv
// dot_pkg: shared definitions for the dot-product accumulate/sink stage.
// Contents: beat width, largest legal beat value, accumulator FSM state
// type, and the helper that sizes occupancy counters.
// Optional feature macro used by the files importing this package:
// DOT_ACC_SAT_EN (saturating accumulation plus a per-result sat bit).
package dot_pkg;

    localparam int PROD_SUM_W = 18;
    localparam int MAX_BEAT   = 260100;   // 4 * 255 * 255

    typedef enum logic {IDLE, ACCUM} state_e;

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dot_accum_sink_if.sv
// dot_accum_sink_if: beat input stream and result output stream of
// dot_accum_sink.
//   in_valid/in_sum/cfg_len : valid-only beat stream with its vector length
//   out_valid/out_ready     : result handshake
//   out_acc                 : result at FIFO head
//   out_sat                 : result saturated (only with DOT_ACC_SAT_EN)
// master = producer/consumer side, slave = dot_accum_sink.
interface dot_accum_sink_if
    import dot_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int LEN_W = 16
);
    logic                  in_valid;
    logic [PROD_SUM_W-1:0] in_sum;
    logic [LEN_W-1:0]      cfg_len;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_W-1:0]      out_acc;
`ifdef DOT_ACC_SAT_EN
    logic                  out_sat;
`endif

    modport master (
        output in_valid, in_sum, cfg_len, out_ready,
`ifdef DOT_ACC_SAT_EN
        input  out_sat,
`endif
        input  out_valid, out_acc
    );

    modport slave (
        input  in_valid, in_sum, cfg_len, out_ready,
`ifdef DOT_ACC_SAT_EN
        output out_sat,
`endif
        output out_valid, out_acc
    );

endinterface

// File: rtl/acc_result_fifo.sv
// acc_result_fifo: synchronous FIFO with a registered head word.
//   push/wdata : write (accepted when not full, or when full and popping)
//   pop        : read (ignored when empty)
//   full/empty : status
//   level      : occupancy 0..DEPTH
//   head       : registered copy of the oldest entry; holds when empty
// DEPTH must be a power of two so the pointers wrap naturally.
module acc_result_fifo
    import dot_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = lvl_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level,
    output logic [W-1:0]     head
);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        cnt_q, cnt_d;
    logic [W-1:0]            head_q, head_d;
    logic                    do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == LVL_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign do_push = push & (~full | do_pop);
    assign level   = cnt_q;
    assign head    = head_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        cnt_d = cnt_q + LVL_W'(do_push) - LVL_W'(do_pop);
        // Head register tracks the entry that will be oldest after this edge.
        if (do_pop) begin
            if (cnt_q > LVL_W'(1))
                head_d = mem_q[rd_ptr_d];
            else if (do_push)
                head_d = wdata;
        end else if (empty && do_push) begin
            head_d = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/dot_accum_sink.sv
// dot_accum_sink: accumulates cfg_len consecutive dot-product beats into one
// sum and queues finished sums in a result FIFO with valid/ready output.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : beat stream in, result stream out (dot_accum_sink_if)
//   fifo_level  : result FIFO occupancy
//   drop_flag   : sticky, a finished result was lost to a full FIFO
//   err_clr     : synchronous clear of drop_flag (a new drop wins)
// Macro DOT_ACC_SAT_EN: saturate at 2^ACC_W-1 instead of wrapping and carry a
// sat bit per result on bus.out_sat.
module dot_accum_sink
    import dot_pkg::*;
#(
    parameter int ACC_W      = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    dot_accum_sink_if.slave             bus,
    output logic [lvl_w(FIFO_DEPTH)-1:0] fifo_level,
    output logic                        drop_flag,
    input  logic                        err_clr
);

`ifdef DOT_ACC_SAT_EN
    localparam int FW = ACC_W + 1;   // {sat, acc}
`else
    localparam int FW = ACC_W;
`endif

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             drop_q, drop_d;
    logic [LEN_W-1:0] len_eff;
    logic [ACC_W-1:0] sum;
    logic             final_beat, push, pop, full, empty;
    logic [FW-1:0]    push_data, head;
`ifdef DOT_ACC_SAT_EN
    logic             sat_q, sat_d, sum_sat;
    logic [ACC_W:0]   sum_wide;
`endif

    always_comb begin
        len_eff = (bus.cfg_len == '0) ? LEN_W'(1) : bus.cfg_len;
        // acc is zero in IDLE, so the same adder yields the first-beat value.
`ifdef DOT_ACC_SAT_EN
        sum_wide  = {1'b0, acc_q} + (ACC_W+1)'(bus.in_sum);
        sum_sat   = sat_q | sum_wide[ACC_W];
        sum       = sum_sat ? '1 : sum_wide[ACC_W-1:0];
        push_data = {sum_sat, sum};
`else
        sum       = acc_q + ACC_W'(bus.in_sum);
        push_data = sum;
`endif
        final_beat = (state_q == IDLE) ? (len_eff == LEN_W'(1))
                                       : (beat_cnt_q == len_q - LEN_W'(1));
        push = bus.in_valid & final_beat;
        pop  = bus.out_ready & ~empty;

        state_d    = state_q;
        acc_d      = acc_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
`ifdef DOT_ACC_SAT_EN
        sat_d      = sat_q;
`endif
        if (bus.in_valid) begin
            if (state_q == IDLE)
                len_d = len_eff;
            if (final_beat) begin
                state_d    = IDLE;
                acc_d      = '0;
                beat_cnt_d = '0;
`ifdef DOT_ACC_SAT_EN
                sat_d      = 1'b0;
`endif
            end else begin
                state_d    = ACCUM;
                acc_d      = sum;
                beat_cnt_d = beat_cnt_q + LEN_W'(1);
`ifdef DOT_ACC_SAT_EN
                sat_d      = sum_sat;
`endif
            end
        end
        drop_d = (push & full & ~pop) | (drop_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            drop_q     <= 1'b0;
`ifdef DOT_ACC_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            drop_q     <= drop_d;
`ifdef DOT_ACC_SAT_EN
            sat_q      <= sat_d;
`endif
        end
    end

    acc_result_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .level (fifo_level),
        .head  (head)
    );

    assign bus.out_valid = ~empty;
    assign bus.out_acc   = head[ACC_W-1:0];
`ifdef DOT_ACC_SAT_EN
    assign bus.out_sat   = head[ACC_W];
`endif
    assign drop_flag     = drop_q;

endmodule

// File: doc/dot_accum_sink.md
Name: dot_accum_sink

Overview:
- Downstream stage of the 4-lane INT8 dot-product pipeline.
- Consumes the 18-bit per-beat dot-product stream (valid-only, no backpressure upstream).
- Accumulates a programmable number of consecutive beats into one wide sum, then queues each finished sum in a small result FIFO.
- Presents results on a valid/ready interface to the writeback/host side.

Parameters:
- ACC_W, 32, accumulator and result width; must be ≥ 18.
- LEN_W, 16, width of the vector-length configuration.
- FIFO_DEPTH, 4, result FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  beat present on in_sum.
- in_sum  in  18  unsigned dot-product beat (max 260100).
- cfg_len  in  LEN_W  beats per vector; sampled on the first beat of each vector; 0 is treated as 1.
- out_valid  out  1  result available at FIFO head.
- out_ready  in  1  consumer accepts the result.
- out_acc  out  ACC_W  accumulated result at FIFO head.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy.
- drop_flag  out  1  sticky: a finished result was lost because the FIFO was full.
- err_clr  in  1  synchronous clear of drop_flag.

Behaviour:
- Reset (async assert, sync-release assumed upstream): FSM=IDLE, acc=0, beat_cnt=0, FIFO empty, out_valid=0, out_acc=0, fifo_level=0, drop_flag=0.
- FSM IDLE:
  - in_valid → latch len = max(cfg_len, 1), acc ← in_sum, beat_cnt ← 1.
  - If len==1, the result is final this beat; stay IDLE. Otherwise go to ACCUM.
- FSM ACCUM:
  - Each in_valid: acc ← acc + in_sum, beat_cnt++.
  - Beat with beat_cnt == len-1 (pre-increment) is final: push the result and return to IDLE.
  - in_valid low: hold; no timeout.
  - cfg_len changes mid-vector are ignored.
- Push value: the final-beat sum (acc + in_sum), written at the same edge the FSM returns to IDLE. That edge sets acc=0 and beat_cnt=0.
- Arithmetic: zero-extend in_sum to ACC_W. The sum wraps modulo 2^ACC_W unless the optional feature is enabled.
- Latency: final beat sampled at edge t → out_valid=1 after edge t if the FIFO was empty. FIFO is fall-through-free: out_acc is registered, head visible one cycle after the push.
- Handshake:
  - Pop on out_valid & out_ready.
  - out_acc and out_valid are stable while out_valid=1 and out_ready=0.
  - out_acc holds its last value when empty (out_valid=0).
- Full + push, no pop: result discarded, drop_flag ← 1. The accumulator still restarts, so vector alignment is preserved.
- Full + push + pop, same cycle: both happen; level unchanged; no drop.
- Empty + push + pop: pop is ignored, since out_valid=0 that cycle.
- err_clr together with a new drop: drop_flag stays 1 (set wins).
- Back-to-back vectors: a new vector's first beat may arrive the cycle after the final beat, with no bubble required.

Optional Feature:
- Macro DOT_ACC_SAT_EN.
- Defined: the accumulator saturates at 2^ACC_W-1. Once saturated it stays there until the vector ends. A per-entry sat bit is stored in the FIFO and exposed on an extra output port out_sat (1 bit, reset 0).
- Undefined: modulo wrap; no out_sat port; FIFO width is ACC_W.

Decomposition:
- Shared package dot_pkg:
  - PROD_SUM_W=18.
  - MAX_BEAT=260100.
  - FSM state enum {IDLE, ACCUM}.
  - Helper function for the clog2 of the level width.
- One sub-module: acc_result_fifo. Parameterised width/depth synchronous FIFO with registered head, push/pop/full/empty/level.
- The FSM and accumulator stay in the top.

Test Plan:
- cfg_len=4; beats 100, 200, 300, 400 on consecutive cycles; out_ready=1 → one result 1000, out_valid one cycle after the 4th beat, fifo_level back to 0.
- cfg_len=0 (treated as 1); beats 7, 9 → two results 7 then 9 on consecutive cycles.
- cfg_len=1; out_ready=0; 5 beats of 1..5 with FIFO_DEPTH=4 → entries 1, 2, 3, 4 held; 5 dropped; drop_flag=1. Then out_ready=1 pops 1, 2, 3, 4 in order. err_clr clears drop_flag.
- FIFO full + push + pop same cycle: level stays 4, no drop, new value is last in order.
- ACC_W=18, cfg_len=2, beats 260100 + 260100:
  - without DOT_ACC_SAT_EN → 520200 mod 262144 = 258056.
  - with it → 262143, out_sat=1.
- Assert rst_n mid-vector (after 2 of 4 beats) with 2 queued results → out_valid=0, fifo_level=0, drop_flag=0. Next 4-beat vector of 10s yields exactly 40.
